// File: rtl/str_bit_serializer.sv
// str_bit_serializer: buffers parallel words in a small FIFO and replays each
// one a bit per clock on out_bit, with an optional idle gap between words.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   in_data/in_len       word payload and bit count (0 or >WIDTH means WIDTH)
//   in_valid/in_ready    push handshake; in_ready is registered
//   flush                synchronous clear of FIFO and current word
//   out_bit/out_valid    serial data and data-bit qualifier (registered)
//   word_start/word_last first/last bit markers (registered)
//   fifo_count           FIFO occupancy
module str_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0,
  parameter int unsigned GAP       = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [$clog2(WIDTH):0] in_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_bit,
  output logic                   out_valid,
  output logic                   word_start,
  output logic                   word_last,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned LW      = $clog2(WIDTH) + 1;
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam int unsigned GW      = 4;
  localparam bit          HAS_GAP = (GAP != 0);

  typedef struct packed {
    logic [LW-1:0]    len;
    logic [WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  entry_t           mem [DEPTH];
  entry_t           head, wr_entry;
  logic [PW-1:0]    rptr, wptr;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] sh, sh_n, aligned;
  logic [LW-1:0]    rem, rem_n;
  logic [GW-1:0]    gcnt;
  logic             push, empty, load, shift, gap_load, gap_dec;
  logic             out_bit_n, out_valid_n, word_start_n, word_last_n;

  assign push       = in_valid && in_ready && !flush;
  assign empty      = (count == '0);
  assign head       = mem[rptr];
  assign fifo_count = count;

  // Length normalisation at push: 0 or overflow becomes the full width
  always_comb begin
    wr_entry.data = in_data;
    wr_entry.len  = in_len;
    if (in_len == '0 || in_len > LW'(WIDTH)) wr_entry.len = LW'(WIDTH);
  end

  // FIFO storage (payload only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_entry;
  end

  // Occupancy; in_ready follows the post-edge count so a full FIFO never accepts
  always_comb begin
    count_n = count;
    if (flush) count_n = '0;
    else       count_n = count + CW'(push) - CW'(load);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      count    <= count_n;
      in_ready <= (count_n < CW'(DEPTH));
      if (flush) begin
        rptr <= '0;
        wptr <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (load) rptr <= rptr + PW'(1);
      end
    end
  end

  // Engine state register plus shift datapath and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      sh         <= '0;
      rem        <= '0;
      gcnt       <= '0;
      out_bit    <= IDLE_BIT;
      out_valid  <= 1'b0;
      word_start <= 1'b0;
      word_last  <= 1'b0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      rem        <= rem_n;
      out_bit    <= out_bit_n;
      out_valid  <= out_valid_n;
      word_start <= word_start_n;
      word_last  <= word_last_n;
      if (gap_load)     gcnt <= GW'(GAP - 1);
      else if (gap_dec) gcnt <= gcnt - GW'(1);
    end
  end

  // Next-state: rem counts bits still to come after the one on out_bit
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    shift    = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    if (flush) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            load    = 1'b1;
            state_n = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (rem != '0) begin
            shift = 1'b1;
          end else if (HAS_GAP) begin
            gap_load = 1'b1;
            state_n  = ST_GAP;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gcnt != '0) begin
            gap_dec = 1'b1;
          end else if (!empty) begin
            load    = 1'b1;
            state_n = ST_SHIFT;
          end else begin
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Output/datapath next values; the word is aligned so the emitted bit is always at one end
  always_comb begin
    out_bit_n    = IDLE_BIT;
    out_valid_n  = 1'b0;
    word_start_n = 1'b0;
    word_last_n  = 1'b0;
    sh_n         = sh;
    rem_n        = rem;
    aligned      = MSB_FIRST ? (head.data << (LW'(WIDTH) - head.len)) : head.data;
    if (load) begin
      out_bit_n    = MSB_FIRST ? aligned[WIDTH-1] : aligned[0];
      sh_n         = MSB_FIRST ? (aligned << 1) : (aligned >> 1);
      rem_n        = head.len - LW'(1);
      out_valid_n  = 1'b1;
      word_start_n = 1'b1;
      word_last_n  = (head.len == LW'(1));
    end else if (shift) begin
      out_bit_n   = MSB_FIRST ? sh[WIDTH-1] : sh[0];
      sh_n        = MSB_FIRST ? (sh << 1) : (sh >> 1);
      rem_n       = rem - LW'(1);
      out_valid_n = 1'b1;
      word_last_n = (rem == LW'(1));
    end
  end

endmodule

// File: tb/tb_str_bit_serializer.sv
// Bench for str_bit_serializer: three configurations (MSB/GAP0, MSB/GAP2,
// LSB/GAP0/idle-high) driven by shared stimulus and checked every cycle
// against a bit-queue reference model, plus directed pattern checks.
module tb_str_bit_serializer;

  logic       clk = 1'b0;
  logic       resetn, in_valid, flush;
  logic [7:0] in_data;
  logic [3:0] in_len;
  logic [2:0] rdy, ob, ov, ws, wl;
  logic [2:0] fc [3];

  always #5 clk = ~clk;

  str_bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(0)) u_msb (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
    .in_ready(rdy[0]), .flush(flush), .out_bit(ob[0]), .out_valid(ov[0]),
    .word_start(ws[0]), .word_last(wl[0]), .fifo_count(fc[0]));

  str_bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(2)) u_gap (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
    .in_ready(rdy[1]), .flush(flush), .out_bit(ob[1]), .out_valid(ov[1]),
    .word_start(ws[1]), .word_last(wl[1]), .fifo_count(fc[1]));

  str_bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP(0)) u_lsb (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
    .in_ready(rdy[2]), .flush(flush), .out_bit(ob[2]), .out_valid(ov[2]),
    .word_start(ws[2]), .word_last(wl[2]), .fifo_count(fc[2]));

  bit cfg_msb  [3] = '{1'b1, 1'b1, 1'b0};
  int cfg_gap  [3] = '{0, 2, 0};
  bit cfg_idle [3] = '{1'b0, 1'b0, 1'b1};

  // Reference model: queue of pending words, queue of bits left in the current word
  logic [11:0] m_q   [3][$];
  bit          m_cur [3][$];
  bit          m_busy[3];
  int          m_gap [3];
  logic        m_ob[3], m_ov[3], m_ws[3], m_wl[3], m_rdy[3];

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] pat;
  int e_gap0 [8] = '{1, 0, 1, 0, 1, 1, -1, -1};
  int e_gap2 [8] = '{1, 0, 1, -1, -1, 0, 1, 1};

  task automatic check(input string tag, input int i, input logic [3:0] act, input logic [3:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s inst%0d: observed %0h expected %0h", tag, i, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_q[i].delete();
      m_cur[i].delete();
      m_busy[i] = 1'b0;
      m_gap[i]  = 0;
      m_ob[i]   = cfg_idle[i];
      m_ov[i]   = 1'b0;
      m_ws[i]   = 1'b0;
      m_wl[i]   = 1'b0;
      m_rdy[i]  = 1'b1;
    end
  endtask

  task automatic model_edge(input int i);
    bit          push, next;
    logic [11:0] w;
    logic [7:0]  d;
    logic [3:0]  nl;
    int          len;
    push = in_valid && m_rdy[i] && !flush;
    nl = in_len;
    if (nl == 4'd0 || nl > 4'd8) nl = 4'd8;
    m_ws[i] = 1'b0;
    m_wl[i] = 1'b0;
    m_ov[i] = 1'b0;
    m_ob[i] = cfg_idle[i];
    next = 1'b0;
    if (flush) begin
      m_q[i].delete();
      m_cur[i].delete();
      m_busy[i] = 1'b0;
      m_gap[i]  = 0;
    end else begin
      if (m_busy[i] && m_cur[i].size() > 0) begin
        m_ob[i] = m_cur[i].pop_front();
        m_ov[i] = 1'b1;
        m_wl[i] = (m_cur[i].size() == 0);
      end else if (m_busy[i]) begin
        m_busy[i] = 1'b0;
        if (cfg_gap[i] > 0) m_gap[i] = cfg_gap[i] - 1;
        else                next = 1'b1;
      end else if (m_gap[i] > 0) begin
        m_gap[i]--;
      end else begin
        next = 1'b1;
      end
      if (next && m_q[i].size() > 0) begin
        w   = m_q[i].pop_front();
        d   = w[7:0];
        len = int'(w[11:8]);
        if (cfg_msb[i]) for (int b = len - 1; b >= 0; b--) m_cur[i].push_back(d[b]);
        else            for (int b = 0; b < len; b++)      m_cur[i].push_back(d[b]);
        m_ob[i]   = m_cur[i].pop_front();
        m_ov[i]   = 1'b1;
        m_ws[i]   = 1'b1;
        m_busy[i] = 1'b1;
        m_wl[i]   = (m_cur[i].size() == 0);
      end
      if (push) m_q[i].push_back({nl, in_data});
    end
    m_rdy[i] = (m_q[i].size() < 4);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check("out_bit",    i, 4'(ob[i]),  4'(m_ob[i]));
      check("out_valid",  i, 4'(ov[i]),  4'(m_ov[i]));
      check("word_start", i, 4'(ws[i]),  4'(m_ws[i]));
      check("word_last",  i, 4'(wl[i]),  4'(m_wl[i]));
      check("in_ready",   i, 4'(rdy[i]), 4'(m_rdy[i]));
      check("fifo_count", i, 4'(fc[i]),  4'(m_q[i].size()));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (resetn) for (int i = 0; i < 3; i++) model_edge(i);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush    = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic push_word(input logic [7:0] d, input logic [3:0] l);
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    in_data  = '0;
    in_len   = '0;
    model_reset();
    cycle();
    cycle();
    check("rst_ready", 0, 4'(rdy[0]), 4'd1);
    check("rst_count", 0, 4'(fc[0]),  4'd0);
    #3 resetn = 1'b1;
    idle(3);

    // 8'h55 MSB-first: 0,1,0,1,... from the edge after the push
    pat = 8'h55;
    push_word(8'h55, 4'd8);
    for (int j = 0; j < 8; j++) begin
      cycle();
      check("p55_bit",   0, 4'(ob[0]), 4'(pat[7-j]));
      check("p55_valid", 0, 4'(ov[0]), 4'd1);
      check("p55_start", 0, 4'(ws[0]), 4'(j == 0));
      check("p55_last",  0, 4'(wl[0]), 4'(j == 7));
    end
    cycle();
    check("p55_after_valid", 0, 4'(ov[0]), 4'd0);
    check("p55_after_bit",   0, 4'(ob[0]), 4'd0);
    idle(10);

    // Back-to-back words, with and without gap
    in_valid = 1'b1; in_data = 8'b0000_0101; in_len = 4'd3;
    cycle();
    in_data = 8'b0000_0011;
    cycle();
    in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) cycle();
      if (e_gap0[j] >= 0) begin
        check("gap0_valid", 0, 4'(ov[0]), 4'd1);
        check("gap0_bit",   0, 4'(ob[0]), 4'(e_gap0[j]));
      end else begin
        check("gap0_idle", 0, 4'(ov[0]), 4'd0);
      end
      if (e_gap2[j] >= 0) begin
        check("gap2_valid", 1, 4'(ov[1]), 4'd1);
        check("gap2_bit",   1, 4'(ob[1]), 4'(e_gap2[j]));
      end else begin
        check("gap2_idle", 1, 4'(ov[1]), 4'd0);
      end
    end
    idle(10);

    // Fill: in_valid held high, FIFO saturates after the fifth accepted word
    in_valid = 1'b1;
    in_len   = 4'd8;
    for (int k = 0; k < 5; k++) begin
      in_data = 8'hA0 + 8'(k);
      cycle();
    end
    check("full_ready", 0, 4'(rdy[0]), 4'd0);
    check("full_count", 0, 4'(fc[0]),  4'd4);
    for (int k = 5; k < 16; k++) begin
      in_data = 8'hA0 + 8'(k);
      cycle();
    end
    idle(90);

    // LSB-first, len 0 means full width
    pat = 8'b0000_0110;
    push_word(pat, 4'd0);
    for (int j = 0; j < 8; j++) begin
      cycle();
      check("lsb_bit",   2, 4'(ob[2]), 4'(pat[j]));
      check("lsb_valid", 2, 4'(ov[2]), 4'd1);
    end
    idle(6);
    push_word(8'h01, 4'd1);
    cycle();
    check("len1_bit",   2, 4'(ob[2]), 4'd1);
    check("len1_start", 2, 4'(ws[2]), 4'd1);
    check("len1_last",  2, 4'(wl[2]), 4'd1);
    check("len1_start", 0, 4'(ws[0]), 4'd1);
    check("len1_last",  0, 4'(wl[0]), 4'd1);
    idle(6);

    // Flush on bit 4 of a word with two more queued and a push offered
    in_valid = 1'b1; in_len = 4'd8;
    in_data = 8'hC3; cycle();
    in_data = 8'h3C; cycle();
    in_data = 8'h99; cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    in_valid = 1'b1; in_data = 8'h77; flush = 1'b1;
    cycle();
    in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("flush_valid", i, 4'(ov[i]), 4'd0);
      check("flush_count", i, 4'(fc[i]), 4'd0);
    end
    idle(3);
    check("flush_discard", 0, 4'(ov[0]), 4'd0);
    push_word(8'h81, 4'd8);
    idle(14);

    // Asynchronous reset mid-word, released between edges
    push_word(8'hFF, 4'd8);
    cycle();
    cycle();
    #2 resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("arst_valid", 0, 4'(ov[0]),  4'd0);
    check("arst_ready", 0, 4'(rdy[0]), 4'd1);
    cycle();
    #3 resetn = 1'b1;
    pat = 8'hA5;
    push_word(8'hA5, 4'd8);
    for (int j = 0; j < 8; j++) begin
      cycle();
      check("a5_bit",   0, 4'(ob[0]), 4'(pat[7-j]));
      check("a5_valid", 0, 4'(ov[0]), 4'd1);
    end
    idle(10);

    // Randomised traffic
    for (int k = 0; k < 800; k++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
      in_len   = 4'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 63) == 0);
      cycle();
    end
    idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
